// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter run sequencer: default widths and FSM state encoding.
package counter_sequencer_pkg;

  localparam int DEF_WIDTH  = 7;
  localparam int DEF_RUNS_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between system control (master) and the counter sequencer (slave).
interface counter_sequencer_if #(
  parameter int WIDTH  = 7,
  parameter int RUNS_W = 8
);
  logic              start;
  logic              pause;
  logic              abort;
  logic              reload;
  logic [WIDTH-1:0]  limit;
  logic [WIDTH-1:0]  q;
  logic              busy;
  logic              done;
  logic [1:0]        state;
  logic [RUNS_W-1:0] runs;

  modport master (
    output start, pause, abort, reload, limit,
    input  q, busy, done, state, runs
  );

  modport slave (
    input  start, pause, abort, reload, limit,
    output q, busy, done, state, runs
  );
endinterface

// File: rtl/counter_sequencer_count_core.sv
// Counter datapath register: synchronous clear has priority over enable.
module count_core #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Count register; clear wins over enable so a restart never increments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= q + WIDTH'(1);
  end

endmodule

// File: rtl/counter_sequencer.sv
// Run controller for the counter datapath: start/pause/abort handshake, terminal
// count detection, one-shot or auto-reload, and a completed-run counter.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; q keeps its last value
//   S_RUN  | counting up one per edge toward the latched limit
//   S_HOLD | paused, q frozen; leaving costs one non-counting edge
//   S_DONE | one-shot terminal reached, single cycle, start ignored
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int RUNS_W = DEF_RUNS_W
) (
  input logic                clk,
  input logic                reset,
  counter_sequencer_if.slave bus
);

  seq_state_t        state_q, state_d;
  logic [WIDTH-1:0]  lim_q;
  logic              mode_q;
  logic              done_q, done_d;
  logic [RUNS_W-1:0] runs_q;
  logic              latch;
  logic              cnt_clr, cnt_en;
  logic [WIDTH-1:0]  cnt;

  count_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .q     (cnt)
  );

  // Next-state and counter control; abort outranks pause, pause outranks terminal count.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    latch   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          cnt_clr = 1'b1;
          latch   = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          cnt_clr = 1'b1;
        end else if (bus.pause) begin
          state_d = S_HOLD;
        end else if (cnt == lim_q) begin
          done_d = 1'b1;
          if (mode_q) cnt_clr = 1'b1;
          else        state_d = S_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          cnt_clr = 1'b1;
        end else if (!bus.pause) begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, done strobe and run counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      runs_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (done_d) runs_q <= runs_q + RUNS_W'(1);
    end
  end

  // Limit and mode are captured only when a start is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lim_q  <= '0;
      mode_q <= 1'b0;
    end else if (latch) begin
      lim_q  <= bus.limit;
      mode_q <= bus.reload;
    end
  end

  assign bus.q     = cnt;
  assign bus.state = state_q;
  assign bus.busy  = (state_q == S_RUN) || (state_q == S_HOLD);
  assign bus.done  = done_q;
  assign bus.runs  = runs_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: vector table, directed corner cases,
// and randomized traffic against a behavioural model.
module tb_counter_sequencer;
  localparam int W  = 7;
  localparam int RW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counter_sequencer_if #(.WIDTH(W), .RUNS_W(RW)) bus ();
  counter_sequencer #(.WIDTH(W), .RUNS_W(RW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model: 0 idle, 1 run, 2 hold, 3 done
  int m_st, m_q, m_lim, m_mode, m_done, m_runs;

  typedef struct {
    logic s, p, a, r;
    int   lim;
    int   eq, est, edone;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_q = 0; m_lim = 0; m_mode = 0; m_done = 0; m_runs = 0;
  endtask

  task automatic model_step();
    m_done = 0;
    case (m_st)
      0: if (bus.start) begin m_st = 1; m_q = 0; m_lim = int'(bus.limit); m_mode = int'(bus.reload); end
      1: begin
        if (bus.abort) begin m_st = 0; m_q = 0; end
        else if (bus.pause) m_st = 2;
        else if (m_q == m_lim) begin
          m_done = 1;
          m_runs = (m_runs + 1) % (1 << RW);
          if (m_mode != 0) m_q = 0; else m_st = 3;
        end else m_q = m_q + 1;
      end
      2: begin
        if (bus.abort) begin m_st = 0; m_q = 0; end
        else if (!bus.pause) m_st = 1;
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".q"},     bus.q,     m_q);
    chk({tag, ".state"}, bus.state, m_st);
    chk({tag, ".busy"},  bus.busy,  (m_st == 1 || m_st == 2));
    chk({tag, ".done"},  bus.done,  m_done);
    chk({tag, ".runs"},  bus.runs,  m_runs);
  endtask

  // one clock: drive at negedge, model at posedge, compare at next negedge
  task automatic cyc(input logic s, p, a, r, input int lim, input string tag);
    bus.start = s; bus.pause = p; bus.abort = a; bus.reload = r; bus.limit = W'(lim);
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, tag);
  endtask

  // async reset pulse between edges; checked before any clock edge
  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    #1 model_reset();
    chk({tag, ".rst_q"},     bus.q, 0);
    chk({tag, ".rst_state"}, bus.state, 0);
    chk({tag, ".rst_busy"},  bus.busy, 0);
    chk({tag, ".rst_done"},  bus.done, 0);
    chk({tag, ".rst_runs"},  bus.runs, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t tbl[9];
  int   ndone, steps, last_done;

  initial begin
    reset = 1'b0;
    bus.start = 0; bus.pause = 0; bus.abort = 0; bus.reload = 0; bus.limit = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_model("reset");
    reset = 1'b1;

    // one-shot limit=5; mid-run start/limit/reload changes must be ignored
    tbl[0] = '{1, 0, 0, 0, 5,  0, 1, 0};
    tbl[1] = '{0, 0, 0, 0, 5,  1, 1, 0};
    tbl[2] = '{1, 0, 0, 1, 1,  2, 1, 0};
    tbl[3] = '{0, 0, 0, 0, 9,  3, 1, 0};
    tbl[4] = '{0, 0, 0, 0, 0,  4, 1, 0};
    tbl[5] = '{0, 0, 0, 0, 0,  5, 1, 0};
    tbl[6] = '{0, 0, 0, 0, 0,  5, 3, 1};
    tbl[7] = '{0, 0, 0, 0, 0,  5, 0, 0};
    tbl[8] = '{0, 0, 0, 0, 0,  5, 0, 0};
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].s, tbl[i].p, tbl[i].a, tbl[i].r, tbl[i].lim, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.q_exp", i),     bus.q,     tbl[i].eq);
      chk($sformatf("tbl%0d.state_exp", i), bus.state, tbl[i].est);
      chk($sformatf("tbl%0d.done_exp", i),  bus.done,  tbl[i].edone);
    end
    chk("oneshot.runs", bus.runs, 1);

    // auto-reload limit=2 from a fresh reset: four terminals, period 3
    do_reset("ar");
    cyc(1, 0, 0, 1, 2, "ar.start");
    ndone = 0; last_done = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 0, 0, 0, 0, "ar.run");
      chk("ar.q_seq", bus.q, (i % 3 == 0) ? 0 : i % 3);
      if (bus.done) begin ndone++; last_done = i; end
    end
    chk("ar.ndone", ndone, 4);
    chk("ar.last_done", last_done, 12);
    chk("ar.runs", bus.runs, 4);
    cyc(0, 0, 1, 0, 0, "ar.abort");
    chk("ar.abort_q", bus.q, 0);

    // pause at q=3 for 4 edges, limit=6: done 5 edges later than unpaused (8 -> 13)
    cyc(1, 0, 0, 0, 6, "pz.start");
    steps = 1;
    idle(3, "pz.run"); steps += 3;
    chk("pz.q3", bus.q, 3);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 0, "pz.hold"); steps++;
      chk("pz.hold_q", bus.q, 3);
      chk("pz.hold_state", bus.state, 2);
    end
    while (!bus.done && steps < 40) begin cyc(0, 0, 0, 0, 0, "pz.resume"); steps++; end
    chk("pz.latency", steps, 13);
    idle(1, "pz.tail");

    // abort in RUN at q=4, abort in HOLD, abort+pause together in RUN
    cyc(1, 0, 0, 0, 9, "ab.start");
    idle(4, "ab.run");
    chk("ab.q4", bus.q, 4);
    cyc(0, 0, 1, 0, 0, "ab.run_abort");
    chk("ab.run_abort_state", bus.state, 0);
    chk("ab.run_abort_q", bus.q, 0);
    cyc(1, 0, 0, 0, 9, "ab.start2");
    idle(2, "ab.run2");
    cyc(0, 1, 0, 0, 0, "ab.pause");
    cyc(0, 1, 1, 0, 0, "ab.hold_abort");
    chk("ab.hold_abort_state", bus.state, 0);
    cyc(1, 0, 0, 0, 9, "ab.start3");
    cyc(0, 1, 1, 0, 0, "ab.both");
    chk("ab.both_state", bus.state, 0);
    chk("ab.runs_kept", bus.runs, 5);

    // limit=0 with start held across DONE; relatch limit=3 on the new run
    cyc(1, 0, 0, 0, 0, "z.start");
    cyc(1, 0, 0, 0, 50, "z.term");
    chk("z.done", bus.done, 1);
    chk("z.state_done", bus.state, 3);
    cyc(1, 0, 0, 0, 50, "z.done2idle");
    chk("z.idle", bus.state, 0);
    cyc(1, 0, 0, 0, 3, "z.restart");
    chk("z.restart_state", bus.state, 1);
    idle(3, "z.run");
    chk("z.q3", bus.q, 3);
    cyc(0, 0, 0, 0, 0, "z.term2");
    chk("z.done2", bus.done, 1);
    idle(1, "z.tail");

    // reset asserted mid-count, limit=9, at q=3; then a normal run
    cyc(1, 0, 0, 0, 9, "rm.start");
    idle(3, "rm.run");
    chk("rm.q3", bus.q, 3);
    do_reset("rm");
    cyc(1, 0, 0, 0, 2, "rm.after");
    idle(4, "rm.after_run");

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset("rnd");
      else cyc($urandom_range(0, 3) == 0,
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 40) == 0,
               $urandom_range(0, 1),
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 12),
               "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
